execute_stage: RTL and testbench

EXECUTE_STAGE -- requirements
Module: execute_stage

---
 rtl/execute_stage.sv | 168 ++++++++++++++++
 tb/tb_execute_stage.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// Execute stage of a classic five-stage pipeline: the ID/EX and EX/MEM
// register banks, operand forwarding muxes, ALU, destination select and
// load-use hazard detection.
module execute_stage (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] id_rs_data,
   input  logic [31:0] id_rt_data,
   input  logic [31:0] id_imm,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic [4:0]  id_rd,
   input  logic [2:0]  id_alu_op,
   input  logic        id_alu_src,
   input  logic        id_reg_dst,
   input  logic        id_reg_write,
   input  logic        id_mem_read,
   input  logic        id_mem_write,
   input  logic        id_mem_to_reg,
   input  logic        flush_i,
   input  logic [1:0]  ForwardA,
   input  logic [1:0]  ForwardB,
   input  logic [31:0] wb_data,
   output logic [4:0]  ID_EX_RegisterRs,
   output logic [4:0]  ID_EX_RegisterRt,
   output logic        stall_o,
   output logic        EX_MEM_RegWrite,
   output logic [4:0]  EX_MEM_RegisterRd,
   output logic [31:0] ex_mem_alu_result,
   output logic [31:0] ex_mem_store_data,
   output logic        ex_mem_mem_read,
   output logic        ex_mem_mem_write,
   output logic        ex_mem_mem_to_reg
);

   // ID/EX bank
   logic [31:0] idex_rs_data;
   logic [31:0] idex_rt_data;
   logic [31:0] idex_imm;
   logic [4:0]  idex_rs;
   logic [4:0]  idex_rt;
   logic [4:0]  idex_rd;
   logic [2:0]  idex_alu_op;
   logic        idex_alu_src;
   logic        idex_reg_dst;
   logic        idex_reg_write;
   logic        idex_mem_read;
   logic        idex_mem_write;
   logic        idex_mem_to_reg;

   // EX-stage combinational results
   logic        bubble;
   logic [31:0] operand_a;
   logic [31:0] forward_b;
   logic [31:0] operand_b;
   logic [31:0] alu_result;
   logic [4:0]  dest_reg;

   // Load-use hazard: the load in EX writes a register the instruction in ID reads
   always_comb begin
      stall_o = idex_mem_read && (idex_rt != 5'd0) &&
                ((idex_rt == id_rs) || (idex_rt == id_rt));
      bubble  = stall_o || flush_i;
   end

   // Forwarding muxes; code 11 falls back to the register-file operand
   always_comb begin
      operand_a = idex_rs_data;
      forward_b = idex_rt_data;
      case (ForwardA)
         2'b10:   operand_a = ex_mem_alu_result;
         2'b01:   operand_a = wb_data;
         default: operand_a = idex_rs_data;
      endcase
      case (ForwardB)
         2'b10:   forward_b = ex_mem_alu_result;
         2'b01:   forward_b = wb_data;
         default: forward_b = idex_rt_data;
      endcase
      operand_b = idex_alu_src ? idex_imm : forward_b;
   end

   // ALU; unused opcodes produce zero rather than a stale value
   always_comb begin
      alu_result = 32'd0;
      case (idex_alu_op)
         3'b000:  alu_result = operand_a & operand_b;
         3'b001:  alu_result = operand_a | operand_b;
         3'b010:  alu_result = operand_a + operand_b;
         3'b110:  alu_result = operand_a - operand_b;
         3'b111:  alu_result = ($signed(operand_a) < $signed(operand_b)) ? 32'd1 : 32'd0;
         default: alu_result = 32'd0;
      endcase
      dest_reg = idex_reg_dst ? idex_rd : idex_rt;
   end

   // ID/EX register: captures the decoded instruction or a bubble on stall/flush
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         idex_rs_data    <= 32'd0;
         idex_rt_data    <= 32'd0;
         idex_imm        <= 32'd0;
         idex_rs         <= 5'd0;
         idex_rt         <= 5'd0;
         idex_rd         <= 5'd0;
         idex_alu_op     <= 3'd0;
         idex_alu_src    <= 1'b0;
         idex_reg_dst    <= 1'b0;
         idex_reg_write  <= 1'b0;
         idex_mem_read   <= 1'b0;
         idex_mem_write  <= 1'b0;
         idex_mem_to_reg <= 1'b0;
      end else if (bubble) begin
         idex_rs_data    <= 32'd0;
         idex_rt_data    <= 32'd0;
         idex_imm        <= 32'd0;
         idex_rs         <= 5'd0;
         idex_rt         <= 5'd0;
         idex_rd         <= 5'd0;
         idex_alu_op     <= 3'd0;
         idex_alu_src    <= 1'b0;
         idex_reg_dst    <= 1'b0;
         idex_reg_write  <= 1'b0;
         idex_mem_read   <= 1'b0;
         idex_mem_write  <= 1'b0;
         idex_mem_to_reg <= 1'b0;
      end else begin
         idex_rs_data    <= id_rs_data;
         idex_rt_data    <= id_rt_data;
         idex_imm        <= id_imm;
         idex_rs         <= id_rs;
         idex_rt         <= id_rt;
         idex_rd         <= id_rd;
         idex_alu_op     <= id_alu_op;
         idex_alu_src    <= id_alu_src;
         idex_reg_dst    <= id_reg_dst;
         idex_reg_write  <= id_reg_write;
         idex_mem_read   <= id_mem_read;
         idex_mem_write  <= id_mem_write;
         idex_mem_to_reg <= id_mem_to_reg;
      end
   end

   // EX/MEM register: always advances, even while ID/EX is being bubbled
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ex_mem_alu_result <= 32'd0;
         ex_mem_store_data <= 32'd0;
         EX_MEM_RegisterRd <= 5'd0;
         EX_MEM_RegWrite   <= 1'b0;
         ex_mem_mem_read   <= 1'b0;
         ex_mem_mem_write  <= 1'b0;
         ex_mem_mem_to_reg <= 1'b0;
      end else begin
         ex_mem_alu_result <= alu_result;
         ex_mem_store_data <= forward_b;
         EX_MEM_RegisterRd <= dest_reg;
         EX_MEM_RegWrite   <= idex_reg_write;
         ex_mem_mem_read   <= idex_mem_read;
         ex_mem_mem_write  <= idex_mem_write;
         ex_mem_mem_to_reg <= idex_mem_to_reg;
      end
   end

   assign ID_EX_RegisterRs = idex_rs;
   assign ID_EX_RegisterRt = idex_rt;

endmodule

// File: tb/tb_execute_stage.sv
// Directed testbench for execute_stage: a table of single instructions
// checked through both pipeline banks, plus hand-written hazard and reset
// sequences.
module tb_execute_stage;

   logic        clock;
   logic        resetN;
   logic [31:0] idRsData, idRtData, idImm, wbData;
   logic [4:0]  idRs, idRt, idRd;
   logic [2:0]  idAluOp;
   logic        idAluSrc, idRegDst, idRegWrite, idMemRead, idMemWrite, idMemToReg;
   logic        flush;
   logic [1:0]  forwardA, forwardB;
   logic [4:0]  exRs, exRt, memRd;
   logic        stall, memRegWrite, memMemRead, memMemWrite, memMemToReg;
   logic [31:0] memResult, memStore;

   int checkCount = 0;
   int errorCount = 0;

   typedef struct {
      logic [2:0]  aluOp;
      logic        aluSrc;
      logic [31:0] rsData;
      logic [31:0] rtData;
      logic [31:0] imm;
      logic [1:0]  fwdA;
      logic [1:0]  fwdB;
      logic [31:0] wb;
      logic        regDst;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic        regWrite;
      logic        memRead;
      logic        memWrite;
      logic        memToReg;
      logic [31:0] expResult;
      logic [31:0] expStore;
      logic [4:0]  expRd;
   } vec_t;

   vec_t vecs[$];

   execute_stage dut (
      .clk_i(clock), .rst_i(resetN),
      .id_rs_data(idRsData), .id_rt_data(idRtData), .id_imm(idImm),
      .id_rs(idRs), .id_rt(idRt), .id_rd(idRd), .id_alu_op(idAluOp),
      .id_alu_src(idAluSrc), .id_reg_dst(idRegDst), .id_reg_write(idRegWrite),
      .id_mem_read(idMemRead), .id_mem_write(idMemWrite), .id_mem_to_reg(idMemToReg),
      .flush_i(flush), .ForwardA(forwardA), .ForwardB(forwardB), .wb_data(wbData),
      .ID_EX_RegisterRs(exRs), .ID_EX_RegisterRt(exRt), .stall_o(stall),
      .EX_MEM_RegWrite(memRegWrite), .EX_MEM_RegisterRd(memRd),
      .ex_mem_alu_result(memResult), .ex_mem_store_data(memStore),
      .ex_mem_mem_read(memMemRead), .ex_mem_mem_write(memMemWrite),
      .ex_mem_mem_to_reg(memMemToReg)
   );

   // Free-running clock, period 10
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clearId();
      idRsData = 0; idRtData = 0; idImm = 0;
      idRs = 0; idRt = 0; idRd = 0; idAluOp = 0;
      idAluSrc = 0; idRegDst = 0; idRegWrite = 0;
      idMemRead = 0; idMemWrite = 0; idMemToReg = 0;
   endtask

   task automatic applyStimulus(input vec_t v);
      idRsData = v.rsData; idRtData = v.rtData; idImm = v.imm;
      idRs = 5'd1; idRt = v.rt; idRd = v.rd; idAluOp = v.aluOp;
      idAluSrc = v.aluSrc; idRegDst = v.regDst; idRegWrite = v.regWrite;
      idMemRead = v.memRead; idMemWrite = v.memWrite; idMemToReg = v.memToReg;
      forwardA = v.fwdA; forwardB = v.fwdB; wbData = v.wb;
   endtask

   task automatic addVec(input logic [2:0] op, input logic src, input logic [31:0] rsD, input logic [31:0] rtD,
                         input logic [31:0] im, input logic [1:0] fa, input logic [1:0] fb, input logic [31:0] wb,
                         input logic rdst, input logic [4:0] rt, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic mw, input logic m2r,
                         input logic [31:0] eRes, input logic [31:0] eStore, input logic [4:0] eRd);
      vec_t v;
      v.aluOp = op; v.aluSrc = src; v.rsData = rsD; v.rtData = rtD; v.imm = im;
      v.fwdA = fa; v.fwdB = fb; v.wb = wb; v.regDst = rdst; v.rt = rt; v.rd = rd;
      v.regWrite = rw; v.memRead = mr; v.memWrite = mw; v.memToReg = m2r;
      v.expResult = eRes; v.expStore = eStore; v.expRd = eRd;
      vecs.push_back(v);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " exRs"}, {27'd0, exRs}, 32'd0);
      checkOutput({tag, " exRt"}, {27'd0, exRt}, 32'd0);
      checkOutput({tag, " stall"}, {31'd0, stall}, 32'd0);
      checkOutput({tag, " regWrite"}, {31'd0, memRegWrite}, 32'd0);
      checkOutput({tag, " rd"}, {27'd0, memRd}, 32'd0);
      checkOutput({tag, " result"}, memResult, 32'd0);
      checkOutput({tag, " store"}, memStore, 32'd0);
      checkOutput({tag, " memCtl"}, {29'd0, memMemRead, memMemWrite, memMemToReg}, 32'd0);
   endtask

   // Puts a load with destination rt into ID
   task automatic applyLoad(input logic [4:0] rt);
      clearId();
      idAluOp = 3'b010; idAluSrc = 1; idImm = 32'd4; idRsData = 32'd100;
      idRs = 5'd2; idRt = rt; idRegWrite = 1; idMemRead = 1; idMemToReg = 1;
   endtask

   // Puts an ADD (1+2 -> r5) reading rs/rt into ID
   task automatic applyDependent(input logic [4:0] rs, input logic [4:0] rt);
      clearId();
      idAluOp = 3'b010; idRsData = 32'd1; idRtData = 32'd2;
      idRs = rs; idRt = rt; idRd = 5'd5; idRegDst = 1; idRegWrite = 1;
   endtask

   initial begin
      //      op     src rsData        rtData        imm           fa    fb    wb     rdst rt  rd  rw mr mw m2r expResult     expStore      expRd
      addVec(3'b010, 0, 32'd5,        32'd7,        32'd0,        2'b00,2'b00,32'd0, 1,   2,  3,  1, 0, 0, 0,  32'd12,       32'd7,        5'd3);
      addVec(3'b110, 0, 32'd10,       32'd3,        32'd0,        2'b00,2'b00,32'd0, 1,   2,  4,  1, 0, 0, 0,  32'd7,        32'd3,        5'd4);
      addVec(3'b000, 0, 32'hFFFF00FF, 32'h0F0F0F0F, 32'd0,        2'b00,2'b00,32'd0, 1,   6,  7,  1, 0, 0, 0,  32'h0F0F000F, 32'h0F0F0F0F, 5'd7);
      addVec(3'b001, 0, 32'hF0,       32'h0F,       32'd0,        2'b00,2'b00,32'd0, 1,   6,  8,  1, 0, 0, 0,  32'hFF,       32'h0F,       5'd8);
      addVec(3'b111, 0, 32'h80000000, 32'd1,        32'd0,        2'b00,2'b00,32'd0, 1,   6,  9,  1, 0, 0, 0,  32'd1,        32'd1,        5'd9);
      addVec(3'b111, 0, 32'd1,        32'h80000000, 32'd0,        2'b00,2'b00,32'd0, 1,   6,  10, 1, 0, 0, 0,  32'd0,        32'h80000000, 5'd10);
      addVec(3'b111, 0, 32'd3,        32'd5,        32'd0,        2'b00,2'b00,32'd0, 1,   6,  11, 1, 0, 0, 0,  32'd1,        32'd5,        5'd11);
      addVec(3'b010, 0, 32'hFFFFFFFF, 32'd1,        32'd0,        2'b00,2'b00,32'd0, 1,   6,  12, 1, 0, 0, 0,  32'd0,        32'd1,        5'd12);
      addVec(3'b011, 0, 32'd5,        32'd7,        32'd0,        2'b00,2'b00,32'd0, 1,   6,  13, 1, 0, 0, 0,  32'd0,        32'd7,        5'd13);
      addVec(3'b100, 0, 32'd5,        32'd7,        32'd0,        2'b00,2'b00,32'd0, 1,   6,  14, 1, 0, 0, 0,  32'd0,        32'd7,        5'd14);
      addVec(3'b101, 0, 32'd5,        32'd7,        32'd0,        2'b00,2'b00,32'd0, 1,   6,  15, 1, 0, 0, 0,  32'd0,        32'd7,        5'd15);
      addVec(3'b010, 1, 32'd10,       32'd99,       32'hFFFFFFFC, 2'b00,2'b00,32'd0, 1,   6,  16, 1, 0, 0, 0,  32'd6,        32'd99,       5'd16);
      addVec(3'b010, 1, 32'd100,      32'h55,       32'd8,        2'b00,2'b00,32'd0, 0,   9,  4,  1, 1, 0, 1,  32'd108,      32'h55,       5'd9);
      addVec(3'b010, 1, 32'd40,       32'hDEAD,     32'd12,       2'b00,2'b00,32'd0, 0,   6,  0,  0, 0, 1, 0,  32'd52,       32'hDEAD,     5'd6);
      addVec(3'b110, 0, 32'd4,        32'd1,        32'd0,        2'b01,2'b00,32'd9, 1,   6,  17, 1, 0, 0, 0,  32'd8,        32'd1,        5'd17);
      addVec(3'b010, 1, 32'd3,        32'd1,        32'd2,        2'b00,2'b01,32'd50,1,   6,  18, 1, 0, 0, 0,  32'd5,        32'd50,       5'd18);
      addVec(3'b110, 0, 32'd4,        32'd1,        32'd0,        2'b11,2'b11,32'd9, 1,   6,  19, 1, 0, 0, 0,  32'd3,        32'd1,        5'd19);

      // Reset held across edges with a live instruction on the ID side
      resetN = 0; flush = 0; forwardA = 0; forwardB = 0; wbData = 0;
      applyDependent(5'd3, 5'd4);
      tick();
      tick();
      checkAllZero("reset");
      clearId();
      #2 resetN = 1;
      tick();

      // Table vectors: ID/EX after one edge, EX/MEM after two
      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         tick();
         checkOutput($sformatf("vec%0d exRs", i), {27'd0, exRs}, 32'd1);
         checkOutput($sformatf("vec%0d exRt", i), {27'd0, exRt}, {27'd0, vecs[i].rt});
         clearId();
         tick();
         checkOutput($sformatf("vec%0d result", i), memResult, vecs[i].expResult);
         checkOutput($sformatf("vec%0d store", i), memStore, vecs[i].expStore);
         checkOutput($sformatf("vec%0d rd", i), {27'd0, memRd}, {27'd0, vecs[i].expRd});
         checkOutput($sformatf("vec%0d regWrite", i), {31'd0, memRegWrite}, {31'd0, vecs[i].regWrite});
         checkOutput($sformatf("vec%0d memCtl", i), {29'd0, memMemRead, memMemWrite, memMemToReg},
                     {29'd0, vecs[i].memRead, vecs[i].memWrite, vecs[i].memToReg});
         forwardA = 0; forwardB = 0; wbData = 0;
      end

      // Forwarding from EX/MEM result and from write-back
      clearId(); idAluOp = 3'b010; idRsData = 32'd20;
      tick();
      clearId(); idAluOp = 3'b110; idRsData = 32'd77; idRtData = 32'd1;
      tick();
      checkOutput("fwd seed", memResult, 32'd20);
      forwardA = 2'b10; forwardB = 2'b01; wbData = 32'd9;
      clearId(); idAluOp = 3'b110; idRsData = 32'd4; idRtData = 32'd1;
      tick();
      checkOutput("fwd exmem-wb", memResult, 32'd11);
      forwardA = 2'b11;
      clearId();
      tick();
      checkOutput("fwd 11-wb", memResult, 32'hFFFFFFFB);
      forwardA = 0; forwardB = 0; wbData = 0;

      // Load-use stall on rs match
      tick();
      applyLoad(5'd8);
      tick();
      applyDependent(5'd8, 5'd3);
      #1 checkOutput("lu stall rs", {31'd0, stall}, 32'd1);
      tick();
      checkOutput("lu load result", memResult, 32'd104);
      checkOutput("lu load rd", {27'd0, memRd}, 32'd8);
      checkOutput("lu load memRead", {31'd0, memMemRead}, 32'd1);
      checkOutput("lu bubble exRs", {27'd0, exRs}, 32'd0);
      checkOutput("lu bubble exRt", {27'd0, exRt}, 32'd0);
      checkOutput("lu stall released", {31'd0, stall}, 32'd0);
      tick();
      checkOutput("lu bubble regWrite", {31'd0, memRegWrite}, 32'd0);
      checkOutput("lu bubble rd", {27'd0, memRd}, 32'd0);
      checkOutput("lu dep captured", {27'd0, exRs}, 32'd8);
      clearId();
      tick();
      checkOutput("lu dep result", memResult, 32'd3);
      checkOutput("lu dep rd", {27'd0, memRd}, 32'd5);

      // Load-use stall on rt match
      applyLoad(5'd8);
      tick();
      applyDependent(5'd0, 5'd8);
      #1 checkOutput("lu stall rt", {31'd0, stall}, 32'd1);
      tick();

      // Load to r0 never stalls
      applyLoad(5'd0);
      tick();
      applyDependent(5'd0, 5'd0);
      #1 checkOutput("lu r0 no stall", {31'd0, stall}, 32'd0);
      tick();
      clearId();
      tick();
      checkOutput("lu r0 dep regWrite", {31'd0, memRegWrite}, 32'd1);
      checkOutput("lu r0 dep rd", {27'd0, memRd}, 32'd5);

      // Flush and stall together give one bubble and no duplicate load
      applyLoad(5'd8);
      tick();
      applyDependent(5'd8, 5'd0);
      flush = 1;
      #1 checkOutput("fs stall", {31'd0, stall}, 32'd1);
      tick();
      flush = 0;
      checkOutput("fs load rd", {27'd0, memRd}, 32'd8);
      checkOutput("fs load regWrite", {31'd0, memRegWrite}, 32'd1);
      checkOutput("fs bubble exRs", {27'd0, exRs}, 32'd0);
      tick();
      checkOutput("fs no dup regWrite", {31'd0, memRegWrite}, 32'd0);
      checkOutput("fs no dup rd", {27'd0, memRd}, 32'd0);
      checkOutput("fs dep once", {27'd0, exRs}, 32'd8);
      clearId();
      tick();
      checkOutput("fs dep rd", {27'd0, memRd}, 32'd5);
      tick();
      checkOutput("fs after regWrite", {31'd0, memRegWrite}, 32'd0);

      // Flush alone squashes the instruction in ID
      applyDependent(5'd2, 5'd3);
      flush = 1;
      tick();
      flush = 0;
      clearId();
      checkOutput("flush exRs", {27'd0, exRs}, 32'd0);
      tick();
      checkOutput("flush regWrite", {31'd0, memRegWrite}, 32'd0);

      // Asynchronous reset mid-stream with an ADD in ID/EX
      applyStimulus(vecs[0]);
      tick();
      clearId();
      forwardA = 0; forwardB = 0; wbData = 0;
      tick();
      applyStimulus(vecs[0]);
      tick();
      clearId();
      #2 resetN = 0;
      #1 checkAllZero("async reset");
      #2 resetN = 1;
      tick();
      tick();
      checkOutput("post reset regWrite", {31'd0, memRegWrite}, 32'd0);
      checkOutput("post reset result", memResult, 32'd0);
      checkOutput("post reset rd", {27'd0, memRd}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
